// File: rtl/ps2_cmd_parser.sv
// ps2_cmd_parser: serial parser for PS/2 command lines (FIRE, RESET, QUEUE, LAUNCH, "SET k v").
// Define PS2_CMD_CLAMP_EN to saturate out-of-range SET values to MAX_VALUE instead of rejecting them.
module ps2_cmd_parser #(
  parameter int LINE_BYTES = 32,
  parameter int NUM_CH     = 2,
  parameter int NUM_W      = 32,
  parameter int MAX_DIGITS = 6,
  parameter int MAX_VALUE  = 99999,
  parameter int CH_INIT    = 0
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [8*LINE_BYTES-1:0]   input_line,
  input  logic                      line_valid,
  output logic                      line_ready,
  output logic [NUM_CH*NUM_W-1:0]   ch_value,
  output logic [NUM_CH-1:0]         ch_update,
  output logic                      cmd_fire,
  output logic                      cmd_reset,
  output logic                      cmd_queue,
  output logic                      cmd_launch,
  output logic                      cmd_err,
  output logic                      busy
);

  localparam int PTR_W = $clog2(LINE_BYTES + 1);
  localparam int ACC_W = NUM_W + 4;
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ACC_W-1:0] ACC_MAX  = ACC_W'(MAX_VALUE);
  localparam logic [7:0]       CH_LIMIT = 8'(8'h30 + NUM_CH);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_DIGIT, S_COMMIT, S_PULSE, S_ERROR} state_t;
  typedef enum logic [1:0] {C_FIRE, C_RESET, C_QUEUE, C_LAUNCH} cmd_t;

  state_t                  state, state_nxt;
  cmd_t                    cmd_sel, cmd_nxt;
  logic [CH_W-1:0]         ch_sel, ch_nxt;
  logic [8*LINE_BYTES-1:0] line_buf;
  logic [PTR_W-1:0]        ptr;
  logic [CNT_W-1:0]        n_dig;
  logic [ACC_W-1:0]        acc, acc_step, acc_sat;
  logic [55:0]             head;
  logic [7:0]              b [7];
  logic [7:0]              cur;
  logic                    accept, cur_term, cur_digit, over, pulse_any;
  logic [NUM_CH-1:0]       upd_d;
  logic                    fire_d, reset_d, queue_d, launch_d, err_d;

  function automatic logic is_term(input logic [7:0] c);
    return (c == 8'h00) || (c == 8'h20) || (c == 8'h0D);
  endfunction

  assign head = line_buf[8*LINE_BYTES-1 -: 56];
  always_comb begin
    for (int i = 0; i < 7; i++) b[i] = head[55-8*i -: 8];
  end

  // Digit phase consumes the buffer MSB-first; shifted-in zeros read as terminators.
  assign cur       = line_buf[8*LINE_BYTES-1 -: 8];
  assign cur_term  = is_term(cur) || (ptr == PTR_W'(LINE_BYTES));
  assign cur_digit = (cur >= 8'h30) && (cur <= 8'h39);
  assign acc_step  = acc * ACC_W'(10) + ACC_W'(cur - 8'h30);
  assign over      = acc_step > ACC_MAX;
  assign acc_sat   = over ? ACC_MAX : acc_step;

  assign pulse_any  = (|ch_update) | cmd_fire | cmd_reset | cmd_queue | cmd_launch | cmd_err;
  assign line_ready = (state == S_IDLE) && !pulse_any;
  assign busy       = ~line_ready;
  assign accept     = line_valid && line_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      cmd_sel <= C_FIRE;
      ch_sel  <= '0;
    end else begin
      state   <= state_nxt;
      cmd_sel <= cmd_nxt;
      ch_sel  <= ch_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd_sel;
    ch_nxt    = ch_sel;
    case (state)
      S_IDLE: if (accept) state_nxt = S_DECODE;
      S_DECODE: begin
        state_nxt = S_ERROR;
        if ({b[0], b[1], b[2], b[3]} == "FIRE" && is_term(b[4])) begin
          state_nxt = S_PULSE;
          cmd_nxt   = C_FIRE;
        end else if ({b[0], b[1], b[2], b[3], b[4]} == "RESET" && is_term(b[5])) begin
          state_nxt = S_PULSE;
          cmd_nxt   = C_RESET;
        end else if ({b[0], b[1], b[2], b[3], b[4]} == "QUEUE" && is_term(b[5])) begin
          state_nxt = S_PULSE;
          cmd_nxt   = C_QUEUE;
        end else if ({b[0], b[1], b[2], b[3], b[4], b[5]} == "LAUNCH" && is_term(b[6])) begin
          state_nxt = S_PULSE;
          cmd_nxt   = C_LAUNCH;
        end else if ({b[0], b[1], b[2], b[3]} == "SET " && b[4] >= 8'h30 && b[4] < CH_LIMIT
                     && b[5] == 8'h20) begin
          state_nxt = S_DIGIT;
          ch_nxt    = CH_W'(b[4] - 8'h30);
        end
      end
      S_DIGIT: begin
        if (cur_term) state_nxt = (n_dig == '0) ? S_ERROR : S_COMMIT;
        else if (!cur_digit || n_dig == CNT_W'(MAX_DIGITS)) state_nxt = S_ERROR;
`ifndef PS2_CMD_CLAMP_EN
        else if (over) state_nxt = S_ERROR;
`endif
      end
      S_COMMIT, S_PULSE, S_ERROR: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      line_buf <= '0;
      ptr      <= '0;
      n_dig    <= '0;
      acc      <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) line_buf <= input_line;
        S_DECODE: begin
          line_buf <= line_buf << 48;
          ptr      <= PTR_W'(6);
          n_dig    <= '0;
          acc      <= '0;
        end
        S_DIGIT: if (state_nxt == S_DIGIT) begin
          acc      <= acc_sat;
          n_dig    <= n_dig + CNT_W'(1);
          ptr      <= ptr + PTR_W'(1);
          line_buf <= line_buf << 8;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    upd_d    = '0;
    fire_d   = 1'b0;
    reset_d  = 1'b0;
    queue_d  = 1'b0;
    launch_d = 1'b0;
    err_d    = 1'b0;
    case (state)
      S_COMMIT: upd_d = NUM_CH'(1) << ch_sel;
      S_PULSE: begin
        fire_d   = (cmd_sel == C_FIRE);
        reset_d  = (cmd_sel == C_RESET);
        queue_d  = (cmd_sel == C_QUEUE);
        launch_d = (cmd_sel == C_LAUNCH);
      end
      S_ERROR: err_d = 1'b1;
      default: ;
    endcase
  end

  // Pulses are registered; line_ready stays low through the pulse cycle via pulse_any.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ch_value   <= {NUM_CH{NUM_W'(CH_INIT)}};
      ch_update  <= '0;
      cmd_fire   <= 1'b0;
      cmd_reset  <= 1'b0;
      cmd_queue  <= 1'b0;
      cmd_launch <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      ch_update  <= upd_d;
      cmd_fire   <= fire_d;
      cmd_reset  <= reset_d;
      cmd_queue  <= queue_d;
      cmd_launch <= launch_d;
      cmd_err    <= err_d;
      if (state == S_COMMIT) ch_value[ch_sel*NUM_W +: NUM_W] <= acc[NUM_W-1:0];
    end
  end

endmodule

// File: tb/tb_ps2_cmd_parser.sv
// tb_ps2_cmd_parser: directed command lines; each issued line queues its expected pulse,
// cycle and channel values, and a monitor matches every pulse the parser emits.
`timescale 1ns/1ps
module tb_ps2_cmd_parser;
  localparam int LB = 32;
  localparam int NC = 2;
  localparam int NW = 32;

  localparam logic [6:0] P_UPD1   = 7'b1000000;
  localparam logic [6:0] P_UPD0   = 7'b0100000;
  localparam logic [6:0] P_FIRE   = 7'b0010000;
  localparam logic [6:0] P_RST    = 7'b0001000;
  localparam logic [6:0] P_QUEUE  = 7'b0000100;
  localparam logic [6:0] P_LAUNCH = 7'b0000010;
  localparam logic [6:0] P_ERR    = 7'b0000001;

  logic            clock = 1'b0;
  logic            resetn = 1'b0;
  logic [8*LB-1:0] input_line = '0;
  logic            line_valid = 1'b0;
  logic            line_ready;
  logic [NC*NW-1:0] ch_value;
  logic [NC-1:0]   ch_update;
  logic            cmd_fire, cmd_reset, cmd_queue, cmd_launch, cmd_err, busy;

  typedef struct {
    logic [6:0]       code;
    int               due;
    logic [NC*NW-1:0] chv;
    int               id;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          line_id = 0;
  logic [31:0] m_ch0 = 32'd0;
  logic [31:0] m_ch1 = 32'd0;

  ps2_cmd_parser dut (
    .clock(clock), .resetn(resetn), .input_line(input_line), .line_valid(line_valid),
    .line_ready(line_ready), .ch_value(ch_value), .ch_update(ch_update),
    .cmd_fire(cmd_fire), .cmd_reset(cmd_reset), .cmd_queue(cmd_queue),
    .cmd_launch(cmd_launch), .cmd_err(cmd_err), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string what, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", what, got, want);
    end
  endtask

  task automatic timeout(input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at cycle %0d", what, cyc);
  endtask

  function automatic logic [8*LB-1:0] pack(input string s);
    logic [8*LB-1:0] v;
    v = '0;
    for (int i = 0; i < s.len(); i++) v[8*LB-1-8*i -: 8] = s[i];
    return v;
  endfunction

  always @(negedge clock) begin
    logic [6:0] code;
    exp_t       e;
    code = {ch_update, cmd_fire, cmd_reset, cmd_queue, cmd_launch, cmd_err};
    if (code != 7'd0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 64'(code), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("line%0d_pulse", e.id), 64'(code), 64'(e.code));
        chk($sformatf("line%0d_cycle", e.id), 64'(cyc), 64'(e.due));
        chk($sformatf("line%0d_ch_value", e.id), ch_value, e.chv);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge where line_ready comes back.
  task automatic issue(input string s, input int lat, input logic [6:0] code, input bit hold);
    int   a;
    bit   ok;
    exp_t e;
    input_line = pack(s);
    line_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (line_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) begin
      timeout({"accept ", s});
      line_valid = 1'b0;
      return;
    end
    a = cyc + 1;
    line_id++;
    e.code = code;
    e.due  = a + lat;
    e.chv  = {m_ch1, m_ch0};
    e.id   = line_id;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (!hold) line_valid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (line_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) chk($sformatf("line%0d_ready_return", line_id), 64'(cyc), 64'(a + lat + 1));
    else timeout({"ready_return ", s});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("reset_ch_value", ch_value, 64'd0);
    chk("reset_line_ready", 64'(line_ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_pulses", 64'({ch_update, cmd_fire, cmd_reset, cmd_queue, cmd_launch, cmd_err}), 64'd0);

    issue("FIRE", 2, P_FIRE, 1'b0);
    m_ch1 = 32'd123;   issue("SET 1 123", 6, P_UPD1, 1'b0);
    issue("RESET", 2, P_RST, 1'b0);
    m_ch0 = 32'd7;     issue("SET 0 007", 6, P_UPD0, 1'b0);
    m_ch1 = 32'd99999; issue("SET 1 99999\015", 8, P_UPD1, 1'b0);
    m_ch0 = 32'd0;     issue("SET 0 0", 4, P_UPD0, 1'b0);
    m_ch1 = 32'd12345; issue("SET 1 012345", 9, P_UPD1, 1'b0);
    issue("FIRE 12", 2, P_FIRE, 1'b0);

`ifdef PS2_CMD_CLAMP_EN
    issue("SET 0 1234567", 9, P_ERR, 1'b0);
`else
    issue("SET 0 1234567", 8, P_ERR, 1'b0);
`endif
    issue("SET 2 5", 2, P_ERR, 1'b0);
    issue("FIREX", 2, P_ERR, 1'b0);
    issue("SET 0 ", 3, P_ERR, 1'b0);
    issue("SET 0 12A", 5, P_ERR, 1'b0);
    issue("SET 0X5", 2, P_ERR, 1'b0);
    issue("LAUNCHED", 2, P_ERR, 1'b0);
    issue("SET", 2, P_ERR, 1'b0);

`ifdef PS2_CMD_CLAMP_EN
    m_ch0 = 32'd99999;
    issue("SET 0 100000", 9, P_UPD0, 1'b0);
`else
    issue("SET 0 100000", 8, P_ERR, 1'b0);
`endif

    // line_valid stays high from QUEUE straight into LAUNCH
    issue("QUEUE", 2, P_QUEUE, 1'b1);
    issue("LAUNCH", 2, P_LAUNCH, 1'b0);

    // Abort a SET line part-way through its digits.
    input_line = pack("SET 1 4567");
    line_valid = 1'b1;
    @(posedge clock);
    #1;
    line_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("abort_busy_before_reset", 64'(line_ready), 64'd0);
    resetn = 1'b0;
    m_ch0 = 32'd0;
    m_ch1 = 32'd0;
    @(negedge clock);
    chk("abort_ch_value_in_reset", ch_value, 64'd0);
    resetn = 1'b1;
    #1;
    chk("abort_ready_after_release", 64'(line_ready), 64'd1);
    repeat (12) @(negedge clock);
    chk("abort_ch_value_later", ch_value, 64'd0);

    m_ch0 = 32'd42;
    issue("SET 0 42", 5, P_UPD0, 1'b0);

    repeat (4) @(negedge clock);
    chk("pending_expectations", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
